// File: rtl/piso_tx_pkg.sv
// Shared types and width helpers for the piso_tx serial transmitter.
package piso_tx_pkg;

    // Frame sequencing states; every non-idle state holds tx_line for one bit period.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module bit_timer
    import piso_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    // While cleared the count parks at zero so the first period after release is full length.
    assign tick = at_last && !clear;

    // Next count: hold at zero when cleared, wrap at the terminal count, else advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: start bit, DATA_W data bits LSB first,
// optional even parity, stop bit. All outputs come straight from flops.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy
);

    localparam int                IDX_W    = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam bit                HAS_PAR  = (PARITY_EN != 0);

    tx_state_e         state_q,    state_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic              parity_q,   parity_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic              tx_line_q,  tx_line_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q,     busy_d;

    logic              tick;
    logic              timer_clear;
    logic              accept;

    // The timer is held in reset while idle so START always gets a full bit period.
    assign timer_clear = (state_q == ST_IDLE);
    assign accept      = tx_valid && tx_ready_q;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .tick  (tick)
    );

    assign tx_ready = tx_ready_q;
    assign tx_line  = tx_line_q;
    assign busy     = busy_q;

    // Next-state logic; tx_line_d is the level of the bit the next state will drive.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        idx_d      = idx_q;
        tx_line_d  = tx_line_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                tx_line_d  = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (accept) begin
                    state_d    = ST_START;
                    shift_d    = tx_data;
                    parity_d   = ^tx_data;
                    idx_d      = '0;
                    tx_line_d  = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_line_d = shift_q[0];
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (idx_q == IDX_LAST) begin
                        if (HAS_PAR) begin
                            state_d   = ST_PARITY;
                            tx_line_d = parity_q;
                        end else begin
                            state_d   = ST_STOP;
                            tx_line_d = 1'b1;
                        end
                    end else begin
                        idx_d     = idx_q + IDX_ONE;
                        shift_d   = shift_q >> 1;
                        tx_line_d = shift_d[0];
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    tx_line_d = 1'b1;
                end
            end

            ST_STOP: begin
                if (tick) begin
                    state_d    = ST_IDLE;
                    tx_line_d  = 1'b1;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                tx_line_d  = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            idx_q      <= '0;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            idx_q      <= idx_d;
            tx_line_q  <= tx_line_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

endmodule
